// File: rtl/denorm2_shift.sv
// Two-stage arithmetic right-shift denormalizer with valid/ready on both sides.
// Define DENORM2_ROUND_EN to round half-up instead of truncating toward -inf.
module denorm2_shift #(
    parameter int MANTISSA = 11,
    parameter int EXPONENT = 5
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MANTISSA-1:0] in_mantissa,
    input  logic [EXPONENT-1:0] in_exponent,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [MANTISSA-1:0] out_mantissa,
    output logic                out_inexact
);

    localparam int SHW = $clog2(MANTISSA + 1);

    logic                adv1;
    logic                adv2;

    logic                s1_valid_q;
    logic                s1_valid_d;
    logic [MANTISSA-1:0] s1_mant_q;
    logic [MANTISSA-1:0] s1_mant_d;
    logic [SHW-1:0]      s1_sh_q;
    logic [SHW-1:0]      s1_sh_d;

    logic                s2_valid_q;
    logic                s2_valid_d;
    logic [MANTISSA-1:0] out_mant_q;
    logic [MANTISSA-1:0] out_mant_d;
    logic                out_inexact_q;
    logic                out_inexact_d;

    logic [SHW-1:0]      sh_clamp;
    logic [MANTISSA-1:0] trunc;
    logic [MANTISSA-1:0] lost_mask;
    logic [MANTISSA-1:0] shifted;
    logic                lost_any;

    assign adv2      = ~s2_valid_q | out_ready;
    assign adv1      = ~s1_valid_q | adv2;
    assign in_ready  = adv1;

    assign out_valid    = s2_valid_q;
    assign out_mantissa = out_mant_q;
    assign out_inexact  = out_inexact_q;

    // Shifts of MANTISSA or more all collapse to a pure sign fill.
    always_comb begin
        sh_clamp = SHW'(MANTISSA);
        if (32'(in_exponent) < 32'(MANTISSA)) begin
            sh_clamp = SHW'(in_exponent);
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mant_d  = s1_mant_q;
        s1_sh_d    = s1_sh_q;
        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_mant_d = in_mantissa;
                s1_sh_d   = sh_clamp;
            end
        end
    end

    always_comb begin
        trunc     = MANTISSA'($signed(s1_mant_q) >>> s1_sh_q);
        lost_mask = ~({MANTISSA{1'b1}} << s1_sh_q);
        lost_any  = |(s1_mant_q & lost_mask);
    end

`ifdef DENORM2_ROUND_EN
    logic round_bit;

    // Bit sh-1 is the half-LSB weight; sh never exceeds MANTISSA.
    always_comb begin
        round_bit = 1'b0;
        if (s1_sh_q != '0) begin
            round_bit = s1_mant_q[s1_sh_q - SHW'(1)];
        end
        shifted = trunc + {{(MANTISSA-1){1'b0}}, round_bit};
    end
`else
    always_comb begin
        shifted = trunc;
    end
`endif

    always_comb begin
        s2_valid_d    = s2_valid_q;
        out_mant_d    = out_mant_q;
        out_inexact_d = out_inexact_q;
        if (adv2) begin
            s2_valid_d    = s1_valid_q;
            out_mant_d    = shifted;
            out_inexact_d = lost_any;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid_q    <= 1'b0;
            s1_mant_q     <= '0;
            s1_sh_q       <= '0;
            s2_valid_q    <= 1'b0;
            out_mant_q    <= '0;
            out_inexact_q <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_mant_q     <= s1_mant_d;
            s1_sh_q       <= s1_sh_d;
            s2_valid_q    <= s2_valid_d;
            out_mant_q    <= out_mant_d;
            out_inexact_q <= out_inexact_d;
        end
    end

endmodule

// File: tb/tb_denorm2_shift.sv
// Self-checking bench for denorm2_shift: directed cases plus random traffic
// scored against an integer floor-division model.
module tb_denorm2_shift;

    localparam int M = 11;
    localparam int E = 5;

    logic         clk = 1'b0;
    logic         rstn;
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] in_mantissa;
    logic [E-1:0] in_exponent;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] out_mantissa;
    logic         out_inexact;

    denorm2_shift #(.MANTISSA(M), .EXPONENT(E)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mantissa  (in_mantissa),
        .in_exponent  (in_exponent),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_mantissa (out_mantissa),
        .out_inexact  (out_inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [M-1:0] m;
        logic         x;
        int           cyc;
    } exp_t;

    exp_t         expq[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           nout = 0;
    int           last_out_cyc = 0;
    bit           lat_en = 0;
    bit           in_fire;
    bit           rdy_seen;
    bit           hold;
    logic [M-1:0] hold_m;
    logic         hold_x;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int floor_div(input int v, input int p);
        int q;
        q = v / p;
        if (v < 0 && q * p != v) q = q - 1;
        return q;
    endfunction

    function automatic exp_t model(input logic [M-1:0] m,
                                   input logic [E-1:0] e);
        exp_t r;
        int   v;
        int   sh;
        int   p;
        int   q;
        v  = int'($signed(m));
        sh = (int'(e) > M) ? M : int'(e);
        p  = 1 << sh;
        q  = floor_div(v, p);
        r.x = (v - q * p) != 0;
`ifdef DENORM2_ROUND_EN
        if (sh > 0) q = floor_div(v + p / 2, p);
`endif
        r.m   = M'(q);
        r.cyc = cyc;
        return r;
    endfunction

    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        rdy_seen = in_ready;
        if (rstn && out_valid && hold) begin
            check("hold_m", 32'(out_mantissa), 32'(hold_m));
            check("hold_x", 32'(out_inexact), 32'(hold_x));
        end
        if (rstn && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = expq.pop_front();
                check("mant", 32'(out_mantissa), 32'(e.m));
                check("inexact", 32'(out_inexact), 32'(e.x));
                if (lat_en) check("latency", 32'(cyc - e.cyc), 32'd2);
                nout++;
                last_out_cyc = cyc;
            end
        end
        in_fire = rstn && in_valid && in_ready;
        if (in_fire) expq.push_back(model(in_mantissa, in_exponent));
        hold   = rstn && out_valid && !out_ready;
        hold_m = out_mantissa;
        hold_x = out_inexact;
        @(posedge clk);
        #1;
        if (!rstn) expq.delete();
    endtask

    task automatic send(input logic [M-1:0] m, input logic [E-1:0] e);
        in_valid    = 1'b1;
        in_mantissa = m;
        in_exponent = e;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && expq.size() != 0; i++) step();
        check(tag, 32'(expq.size()), 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_ov"}, 32'(out_valid), 32'd0);
        check({tag, "_om"}, 32'(out_mantissa), 32'd0);
        check({tag, "_ox"}, 32'(out_inexact), 32'd0);
        check({tag, "_ir"}, 32'(in_ready), 32'd1);
    endtask

    logic [M-1:0] bp_m [4];
    logic [E-1:0] bp_e [4];

    initial begin
        int idx;
        int first_cyc;
        int n0;
        rstn        = 1'b0;
        in_valid    = 1'b0;
        in_mantissa = '0;
        in_exponent = '0;
        out_ready   = 1'b1;
        step();
        step();
        chk_reset("rst");
        rstn = 1'b1;

        // Directed, unstalled: each result must appear exactly 2 cycles later.
        lat_en = 1;
        send(11'h100, 5'd1);
        step();
        step();
        send(11'h600, 5'd3);
        send(11'h007, 5'd2);
        send(11'h3FF, 5'd31);
        send(11'h7FF, 5'd31);
        send(11'h000, 5'd17);
        send(11'h455, 5'd0);
        send(11'h400, 5'd11);
        send(11'h001, 5'd10);
        drain("drain_dir");
        lat_en = 0;

        // Backpressure: two beats fill the pipe, then in_ready must drop.
        bp_m[0] = 11'h100; bp_e[0] = 5'd1;
        bp_m[1] = 11'h200; bp_e[1] = 5'd2;
        bp_m[2] = 11'h400; bp_e[2] = 5'd3;
        bp_m[3] = 11'h040; bp_e[3] = 5'd0;
        idx = 0;
        n0 = nout;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid    = 1'b1;
            in_mantissa = bp_m[idx];
            in_exponent = bp_e[idx];
            step();
            if (in_fire) idx++;
        end
        check("bp_ready", 32'(rdy_seen), 32'd0);
        check("bp_accepted", 32'(idx), 32'd2);
        out_ready = 1'b1;
        first_cyc = cyc + 1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            in_valid    = 1'b1;
            in_mantissa = bp_m[idx];
            in_exponent = bp_e[idx];
            step();
            if (in_fire) idx++;
        end
        drain("drain_bp");
        check("bp_count", 32'(nout - n0), 32'd4);
        check("bp_nogap", 32'(last_out_cyc - first_cyc), 32'd3);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send(11'h123, 5'd2);
        send(11'h321, 5'd4);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk_reset("midrst");
        out_ready = 1'b1;
        lat_en = 1;
        send(11'h7F0, 5'd4);
        drain("drain_rst");
        lat_en = 0;

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            case ($urandom % 6)
                0:       in_mantissa = '0;
                1:       in_mantissa = {M{1'b1}};
                2:       in_mantissa = {1'b1, {(M-1){1'b0}}};
                default: in_mantissa = M'($urandom);
            endcase
            in_exponent = E'($urandom);
            step();
        end
        drain("drain_rand");
        check("rand_outs", 32'(nout > 100), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
